// File: rtl/vision_test_ctrl.sv
// vision_test_ctrl: response side of the E-optotype vision tester.
// Judges debounced key/confirm pulses against the displayed direction,
// steps the acuity level, and draws new directions from a free-running LFSR.
module vision_test_ctrl #(
   parameter int         START_LEVEL = 7,
   parameter int         MAX_LEVEL   = 9,
   parameter int         MAX_MISS    = 2,
   parameter int         TIMEOUT_S   = 5,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       start,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       confirm,
   output logic       active,
   output logic [1:0] dir,
   output logic [3:0] level,
   output logic [3:0] disp_int,
   output logic [3:0] disp_frac,
   output logic [1:0] sel,
   output logic       sel_valid,
   output logic       done
);

   localparam int TW = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
   localparam int MW = (MAX_MISS  < 1) ? 1 : $clog2(MAX_MISS + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHOW, S_JUDGE, S_DONE} state_t;

   state_t          state, state_n;
   logic [7:0]      lfsr;
   logic            lfsr_fb;
   logic [1:0]      dir_n, sel_n, key_dir;
   logic [3:0]      level_n;
   logic            sel_valid_n, timed_out, timed_out_n;
   logic [MW-1:0]   miss_cnt, miss_cnt_n, miss_inc;
   logic [TW-1:0]   timer, timer_n, timer_inc;
   logic            key_any, hit, go_show;

   assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign key_any   = key_up | key_down | key_left | key_right;
   assign miss_inc  = miss_cnt + 1'b1;
   assign timer_inc = timer + 1'b1;
   assign hit       = !timed_out && (sel == dir);
   assign active    = (state == S_SHOW) || (state == S_JUDGE);
   assign done      = (state == S_DONE);

   // simultaneous keys resolve up > down > left > right
   always_comb begin
      key_dir = 2'b11;
      if (key_up)        key_dir = 2'b00;
      else if (key_down) key_dir = 2'b01;
      else if (key_left) key_dir = 2'b10;
   end

   // acuity display: level 9 shows 1.0, otherwise 0.(level+1)
   always_comb begin
      disp_int  = 4'd0;
      disp_frac = level + 4'd1;
      if (level == 4'd9) begin
         disp_int  = 4'd1;
         disp_frac = 4'd0;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_n;
   end

   // next-state and datapath next values; start overrides everything else
   always_comb begin
      state_n     = state;
      dir_n       = dir;
      level_n     = level;
      sel_n       = sel;
      sel_valid_n = sel_valid;
      miss_cnt_n  = miss_cnt;
      timer_n     = timer;
      timed_out_n = timed_out;
      go_show     = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               level_n    = 4'(START_LEVEL);
               miss_cnt_n = '0;
               go_show    = 1'b1;
            end
         end
         S_SHOW: begin
            if (start) begin
               level_n    = 4'(START_LEVEL);
               miss_cnt_n = '0;
               go_show    = 1'b1;
            end else begin
               if (key_any) begin
                  sel_n       = key_dir;
                  sel_valid_n = 1'b1;
               end
               // a valid confirm beats a timeout landing on the same cycle
               if (confirm && (sel_valid || key_any)) begin
                  state_n     = S_JUDGE;
                  timed_out_n = 1'b0;
               end else if (tick_1hz) begin
                  timer_n = timer_inc;
                  if (timer_inc >= TW'(TIMEOUT_S)) begin
                     state_n     = S_JUDGE;
                     timed_out_n = 1'b1;
                  end
               end
            end
         end
         S_JUDGE: begin
            if (start) begin
               level_n    = 4'(START_LEVEL);
               miss_cnt_n = '0;
               go_show    = 1'b1;
            end else if (hit) begin
               if (level < 4'(MAX_LEVEL)) begin
                  level_n    = level + 4'd1;
                  miss_cnt_n = '0;
                  go_show    = 1'b1;
               end else begin
                  state_n = S_DONE;
               end
            end else if (miss_inc < MW'(MAX_MISS)) begin
               miss_cnt_n = miss_inc;
               go_show    = 1'b1;
            end else begin
               level_n = (level == 4'd0) ? 4'd0 : level - 4'd1;
               state_n = S_DONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // every entry into SHOW draws a fresh direction and clears the trial
      if (go_show) begin
         state_n     = S_SHOW;
         dir_n       = lfsr[1:0];
         sel_valid_n = 1'b0;
         timer_n     = '0;
      end
   end

   // datapath registers; LFSR free-runs in every state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr      <= LFSR_SEED;
         dir       <= 2'b00;
         level     <= 4'(START_LEVEL);
         sel       <= 2'b00;
         sel_valid <= 1'b0;
         miss_cnt  <= '0;
         timer     <= '0;
         timed_out <= 1'b0;
      end else begin
         lfsr      <= {lfsr[6:0], lfsr_fb};
         dir       <= dir_n;
         level     <= level_n;
         sel       <= sel_n;
         sel_valid <= sel_valid_n;
         miss_cnt  <= miss_cnt_n;
         timer     <= timer_n;
         timed_out <= timed_out_n;
      end
   end

endmodule

// File: tb/tb_vision_test_ctrl.sv
// Bench for vision_test_ctrl: reference LFSR plus a level/miss model feed a
// scoreboard of expected judge outcomes.
module tb_vision_test_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0, start = 1'b0, confirm = 1'b0;
   logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
   logic       active, sel_valid, done;
   logic [1:0] dir, sel;
   logic [3:0] level, disp_int, disp_frac;

   always #5 clk = ~clk;

   vision_test_ctrl dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start),
      .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
      .confirm(confirm), .active(active), .dir(dir), .level(level),
      .disp_int(disp_int), .disp_frac(disp_frac), .sel(sel), .sel_valid(sel_valid),
      .done(done)
   );

   // reference LFSR: Fibonacci, taps 8,6,5,4, seed A5
   logic [7:0] lfsr_m;
   always @(posedge clk or negedge rst) begin
      if (!rst) lfsr_m <= 8'hA5;
      else      lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end

   typedef struct {
      logic [3:0] old_level;
      logic [3:0] level;
      logic       done;
      logic [1:0] dir;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail = 0;
   logic [3:0] m_level = 4'd7;
   int         m_miss = 0;
   logic       m_done = 1'b0;
   logic [1:0] cur_dir = 2'b00;
   logic       obs_j_active;
   logic [3:0] obs_j_level;

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_in;
      tick_1hz = 0; start = 0; confirm = 0;
      key_up = 0; key_down = 0; key_left = 0; key_right = 0;
   endtask

   task automatic set_key(input logic [1:0] k);
      case (k)
         2'b00: key_up = 1;
         2'b01: key_down = 1;
         2'b10: key_left = 1;
         default: key_right = 1;
      endcase
   endtask

   task automatic do_start;
      logic [1:0] nd;
      start = 1;
      nd = lfsr_m[1:0];
      step;
      start = 0;
      cur_dir = nd;
      m_level = 4'd7; m_miss = 0; m_done = 0;
   endtask

   task automatic model_judge(input bit h, output exp_t e);
      e.old_level = m_level;
      if (h) begin
         if (m_level < 4'd9) begin m_level = m_level + 4'd1; m_miss = 0; end
         else m_done = 1;
      end else if (m_miss + 1 < 2) begin
         m_miss = m_miss + 1;
      end else begin
         if (m_level != 4'd0) m_level = m_level - 4'd1;
         m_done = 1;
      end
      e.level = m_level;
      e.done  = m_done;
      e.dir   = 2'b00;
   endtask

   // called while the DUT sits in JUDGE; captures the direction it will load
   task automatic finish_judge(input exp_t e_in);
      exp_t e;
      e = e_in;
      obs_j_active = active;
      obs_j_level  = level;
      e.dir = lfsr_m[1:0];
      sb.push_back(e);
      step;
      if (!m_done) cur_dir = e.dir;
   endtask

   task automatic run_trial(input logic [1:0] k, input logic tk);
      exp_t e;
      set_key(k);
      confirm = 1;
      tick_1hz = tk;
      model_judge(k == cur_dir, e);
      step;
      clr_in;
      finish_judge(e);
   endtask

   task automatic run_timeout;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         tick_1hz = 1;
         step;
         tick_1hz = 0;
         if (i < 4) step;
      end
      model_judge(1'b0, e);
      finish_judge(e);
   endtask

   task automatic test_reset;
      clr_in;
      rst = 0;
      step; step;
      n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (level !== 4'd7) begin n_fail++; $display("FAIL reset_level: got %0d expected 7", level); end
      n_checks++; if (dir !== 2'b00 || sel !== 2'b00 || sel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dirsel: got dir=%b sel=%b sv=%b expected 00/00/0", dir, sel, sel_valid); end
      n_checks++; if ({disp_int, disp_frac} !== 8'h08) begin n_fail++; $display("FAIL reset_disp: got %0d/%0d expected 0/8", disp_int, disp_frac); end
      rst = 1;
      step;
   endtask

   task automatic test_basic_hit;
      exp_t e;
      do_start;
      n_checks++; if (active !== 1'b1 || level !== 4'd7) begin n_fail++; $display("FAIL t1_start: got active=%b level=%0d expected 1/7", active, level); end
      n_checks++; if (dir !== cur_dir) begin n_fail++; $display("FAIL t1_dir: got %b expected %b", dir, cur_dir); end
      confirm = 1; step; confirm = 0; step;
      n_checks++; if (active !== 1'b1 || sel_valid !== 1'b0 || level !== 4'd7 || dir !== cur_dir) begin n_fail++; $display("FAIL t1_lone_confirm: got active=%b sv=%b level=%0d dir=%b expected 1/0/7/%b", active, sel_valid, level, dir, cur_dir); end
      set_key(cur_dir); step; clr_in;
      n_checks++; if (sel !== cur_dir || sel_valid !== 1'b1) begin n_fail++; $display("FAIL t1_sel: got %b/%b expected %b/1", sel, sel_valid, cur_dir); end
      confirm = 1;
      model_judge(1'b1, e);
      step; clr_in;
      finish_judge(e);
      e = sb.pop_front();
      n_checks++; if (obs_j_active !== 1'b1 || obs_j_level !== e.old_level) begin n_fail++; $display("FAIL t1_judge_cycle: got active=%b level=%0d expected 1/%0d", obs_j_active, obs_j_level, e.old_level); end
      n_checks++; if (level !== e.level || done !== e.done) begin n_fail++; $display("FAIL t1_level: got %0d/%b expected %0d/%b", level, done, e.level, e.done); end
      n_checks++; if ({disp_int, disp_frac} !== 8'h09) begin n_fail++; $display("FAIL t1_disp: got %0d/%0d expected 0/9", disp_int, disp_frac); end
      n_checks++; if (dir !== e.dir || sel_valid !== 1'b0) begin n_fail++; $display("FAIL t1_newdir: got %b/%b expected %b/0", dir, sel_valid, e.dir); end
   endtask

   task automatic test_two_misses;
      exp_t e;
      do_start;
      n_checks++; if (level !== 4'd7) begin n_fail++; $display("FAIL t2_restart: got %0d expected 7", level); end
      for (int i = 0; i < 2; i++) begin
         run_trial(cur_dir ^ 2'b01, 1'b0);
         e = sb.pop_front();
         n_checks++; if (level !== e.level || done !== e.done) begin n_fail++; $display("FAIL t2_miss%0d: got %0d/%b expected %0d/%b", i, level, done, e.level, e.done); end
         if (!e.done) begin
            n_checks++; if (dir !== e.dir) begin n_fail++; $display("FAIL t2_dir%0d: got %b expected %b", i, dir, e.dir); end
         end
      end
      n_checks++; if (active !== 1'b0 || {disp_int, disp_frac} !== 8'h07) begin n_fail++; $display("FAIL t2_final: got active=%b disp=%0d/%0d expected 0 0/7", active, disp_int, disp_frac); end
      set_key(2'b00); confirm = 1; step; clr_in; step;
      n_checks++; if (done !== 1'b1 || level !== 4'd6) begin n_fail++; $display("FAIL t2_done_ignore: got %b/%0d expected 1/6", done, level); end
   endtask

   task automatic test_back_to_back_hits;
      exp_t e;
      do_start;
      n_checks++; if (done !== 1'b0 || active !== 1'b1 || level !== 4'd7) begin n_fail++; $display("FAIL t3_start: got done=%b active=%b level=%0d expected 0/1/7", done, active, level); end
      for (int i = 0; i < 3; i++) begin
         run_trial(cur_dir, 1'b0);
         e = sb.pop_front();
         n_checks++; if (level !== e.level || done !== e.done) begin n_fail++; $display("FAIL t3_hit%0d: got %0d/%b expected %0d/%b", i, level, done, e.level, e.done); end
         if (i == 1) begin
            n_checks++; if ({disp_int, disp_frac} !== 8'h10) begin n_fail++; $display("FAIL t3_disp: got %0d/%0d expected 1/0", disp_int, disp_frac); end
         end
      end
      n_checks++; if (done !== 1'b1 || level !== 4'd9) begin n_fail++; $display("FAIL t3_final: got %b/%0d expected 1/9", done, level); end
   endtask

   task automatic test_timeout;
      exp_t e;
      do_start;
      set_key(cur_dir); step; clr_in;   // a correct selection never confirmed
      for (int i = 0; i < 2; i++) begin
         run_timeout;
         e = sb.pop_front();
         n_checks++; if (level !== e.level || done !== e.done) begin n_fail++; $display("FAIL t4_timeout%0d: got %0d/%b expected %0d/%b", i, level, done, e.level, e.done); end
      end
      n_checks++; if (level !== 4'd6 || done !== 1'b1) begin n_fail++; $display("FAIL t4_final: got %0d/%b expected 6/1", level, done); end
      do_start;
      for (int i = 0; i < 4; i++) begin
         tick_1hz = 1; step; tick_1hz = 0; step;
      end
      run_trial(cur_dir, 1'b1);
      e = sb.pop_front();
      n_checks++; if (level !== e.level || done !== e.done) begin n_fail++; $display("FAIL t4_confirm_wins: got %0d/%b expected %0d/%b", level, done, e.level, e.done); end
   endtask

   task automatic test_key_priority;
      exp_t e;
      do_start;
      key_up = 1; key_right = 1; step; clr_in;
      n_checks++; if (sel !== 2'b00 || sel_valid !== 1'b1) begin n_fail++; $display("FAIL t5_prio: got %b/%b expected 00/1", sel, sel_valid); end
      run_trial(2'b10, 1'b0);
      e = sb.pop_front();
      n_checks++; if (level !== e.level || done !== e.done) begin n_fail++; $display("FAIL t5_judge: got %0d/%b expected %0d/%b", level, done, e.level, e.done); end
      n_checks++; if (sel !== 2'b10) begin n_fail++; $display("FAIL t5_sel: got %b expected 10", sel); end
   endtask

   task automatic test_restart_and_reset;
      exp_t e;
      do_start;
      run_trial(cur_dir, 1'b0);
      e = sb.pop_front();
      n_checks++; if (level !== e.level) begin n_fail++; $display("FAIL t6_hit: got %0d expected %0d", level, e.level); end
      run_trial(cur_dir ^ 2'b11, 1'b0);
      e = sb.pop_front();
      n_checks++; if (level !== 4'd8 || done !== 1'b0) begin n_fail++; $display("FAIL t6_miss1: got %0d/%b expected 8/0", level, done); end
      do_start;
      n_checks++; if (level !== 4'd7 || active !== 1'b1) begin n_fail++; $display("FAIL t6_restart: got %0d/%b expected 7/1", level, active); end
      run_trial(cur_dir ^ 2'b01, 1'b0);
      e = sb.pop_front();
      n_checks++; if (done !== e.done || level !== e.level) begin n_fail++; $display("FAIL t6_misscnt_clr: got %0d/%b expected %0d/%b", level, done, e.level, e.done); end
      set_key(cur_dir); confirm = 1; step; clr_in;
      n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL t6_in_judge: got %b expected 1", active); end
      rst = 0;
      #1;
      n_checks++; if (active !== 1'b0 || done !== 1'b0 || level !== 4'd7 || dir !== 2'b00 || sel !== 2'b00 || sel_valid !== 1'b0) begin n_fail++; $display("FAIL t6_async_rst: got a=%b d=%b l=%0d dir=%b sel=%b sv=%b expected 0/0/7/00/00/0", active, done, level, dir, sel, sel_valid); end
      @(negedge clk);
      rst = 1;
      m_level = 4'd7; m_miss = 0; m_done = 0;
      set_key(2'b01); confirm = 1; step; clr_in; step;
      n_checks++; if (active !== 1'b0 || sel_valid !== 1'b0) begin n_fail++; $display("FAIL t6_idle_ignore: got %b/%b expected 0/0", active, sel_valid); end
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_basic_hit;
      test_two_misses;
      test_back_to_back_hits;
      test_timeout;
      test_key_priority;
      test_restart_and_reset;
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
